l1_inst_cache_dm_cwf: RTL and testbench

- Parametrised successor to the fixed 8-beat L1 instruction cache. Sits between the fetch unit and the 64-bit instruction memory port.
- Direct-mapped, with configurable line length and entry count.
- On a miss it refills critical-beat-first with wrap-around and forwards the requested instruction as soon as its beat arrives (early restart).
- Supports a whole-cache flush, including a flush requested mid-refill.

---
 rtl/l1_inst_cache_dm_cwf.sv | 211 +++++++++++++++++++++
 tb/tb_l1_inst_cache_dm_cwf.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_inst_cache_dm_cwf.sv
// Direct-mapped L1 instruction cache, refills critical-beat-first with wrap and forwards the critical word early.
// Hit: instruction valid 1 cycle after accept. Miss: critical word 1 cycle after its beat returns.
// Fetch is locked while a result is held (iNEXT_LOCK), while a miss is pending or refilling, and on flush; requests wait on iINST_LOCK.
module l1_inst_cache_dm_cwf #(
    parameter int P_LINE_BEATS = 8,
    parameter int P_ENTRY      = 16,
    parameter int P_ADDR_W     = 32
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iFLUSH,
    output logic                oINST_REQ,
    input  logic                iINST_LOCK,
    output logic [P_ADDR_W-1:0] oINST_ADDR,
    input  logic                iINST_VALID,
    input  logic [63:0]         iINST_DATA,
    input  logic                iNEXT_FETCH_REQ,
    output logic                oNEXT_FETCH_LOCK,
    input  logic [P_ADDR_W-1:0] iNEXT_FETCH_ADDR,
    output logic                oNEXT_0_INST_VALID,
    output logic [31:0]         oNEXT_0_INST,
    input  logic                iNEXT_LOCK
);

    localparam int BW    = $clog2(P_LINE_BEATS);
    localparam int OFS   = BW + 3;
    localparam int IDX   = $clog2(P_ENTRY);
    localparam int TAG_W = P_ADDR_W - OFS - IDX;

    localparam logic [BW-1:0] BEAT_ONE = BW'(1);
    localparam logic [BW:0]   NUM_ONE  = (BW+1)'(1);
    localparam logic [BW:0]   NUM_ALL  = (BW+1)'(P_LINE_BEATS);
    localparam logic [BW:0]   NUM_LAST = NUM_ALL - NUM_ONE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEMREQ = 2'd1,
        MEMGET = 2'd2,
        FILL   = 2'd3
    } state_t;

    // storage arrays (no reset: only the valid bits carry meaning after reset)
    logic [TAG_W-1:0]   tag_arr  [P_ENTRY];
    logic [63:0]        data_arr [P_ENTRY][P_LINE_BEATS];
    logic [63:0]        line_buf [P_LINE_BEATS];
    logic [P_ENTRY-1:0] valid;

    // control state
    state_t              state;
    logic [P_ADDR_W-1:0] req_addr;
    logic [BW-1:0]       req_cnt;
    logic [BW:0]         req_num;
    logic [BW-1:0]       rcv_cnt;
    logic [BW:0]         rcv_num;
    logic                flush_pend;
    logic                miss_pend;
    logic                out_vld;
    logic [31:0]         out_inst;

    // fetch-side lookup, straight off the incoming address
    logic [TAG_W-1:0] f_tag;
    logic [IDX-1:0]   f_idx;
    logic [BW-1:0]    f_beat;
    logic [63:0]      f_dat;
    logic [31:0]      f_word;
    logic             f_hit;
    logic             fetch_acc;
    logic             consume;

    // refill-side fields of the latched miss address
    logic [TAG_W-1:0] r_tag;
    logic [IDX-1:0]   r_idx;
    logic [BW-1:0]    crit;
    logic [BW-1:0]    req_beat;
    logic [BW-1:0]    rcv_beat;
    logic [BW:0]      rcv_num_nxt;
    logic [31:0]      crit_word;
    logic             issue;
    logic             beat_in;
    logic             fill_go;
    logic             unused_addr_bits;

    assign f_tag  = iNEXT_FETCH_ADDR[P_ADDR_W-1 -: TAG_W];
    assign f_idx  = iNEXT_FETCH_ADDR[OFS +: IDX];
    assign f_beat = iNEXT_FETCH_ADDR[3 +: BW];
    assign f_dat  = data_arr[f_idx][f_beat];
    assign f_word = iNEXT_FETCH_ADDR[2] ? f_dat[63:32] : f_dat[31:0];
    assign f_hit  = valid[f_idx] && (tag_arr[f_idx] == f_tag);

    assign r_tag    = req_addr[P_ADDR_W-1 -: TAG_W];
    assign r_idx    = req_addr[OFS +: IDX];
    assign crit     = req_addr[3 +: BW];
    assign req_beat = crit + req_cnt;
    assign rcv_beat = crit + rcv_cnt;
    assign crit_word = req_addr[2] ? iINST_DATA[63:32] : iINST_DATA[31:0];

    // instruction byte lanes are implied by 4-byte alignment
    assign unused_addr_bits = ^{iNEXT_FETCH_ADDR[1:0], req_addr[1:0]};

    assign oNEXT_FETCH_LOCK = (state != IDLE) || iFLUSH || (out_vld && iNEXT_LOCK) || miss_pend;
    assign fetch_acc        = iNEXT_FETCH_REQ && !oNEXT_FETCH_LOCK;
    assign consume          = out_vld && !iNEXT_LOCK;

    assign issue       = (state == MEMREQ) && !iINST_LOCK;
    assign beat_in     = ((state == MEMREQ) || (state == MEMGET)) && iINST_VALID;
    assign rcv_num_nxt = rcv_num + {{BW{1'b0}}, beat_in};
    assign fill_go     = (state == FILL) && !(out_vld && iNEXT_LOCK);

    assign oINST_REQ          = (state == MEMREQ);
    assign oINST_ADDR         = (state == MEMREQ) ? {r_tag, r_idx, req_beat, 3'b000} : '0;
    assign oNEXT_0_INST_VALID = out_vld;
    assign oNEXT_0_INST       = out_inst;

    // control FSM: lookup result register, refill sequencing, valid bits and flush handling
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_cnt    <= '0;
            req_num    <= '0;
            rcv_cnt    <= '0;
            rcv_num    <= '0;
            flush_pend <= 1'b0;
            miss_pend  <= 1'b0;
            out_vld    <= 1'b0;
            out_inst   <= '0;
            valid      <= '0;
        end else begin
            // result register: hit data, else the forwarded critical word, else drain on consume
            if (fetch_acc) begin
                req_addr  <= iNEXT_FETCH_ADDR;
                out_vld   <= f_hit;
                miss_pend <= !f_hit;
                if (f_hit) begin
                    out_inst <= f_word;
                end
            end else if (beat_in && (rcv_num == '0)) begin
                out_vld  <= 1'b1;
                out_inst <= crit_word;
            end else if (consume) begin
                out_vld <= 1'b0;
            end

            if (beat_in) begin
                rcv_cnt <= rcv_cnt + BEAT_ONE;
                rcv_num <= rcv_num_nxt;
            end

            // a flush arriving mid-refill is remembered and applied when the line is retired
            if (iFLUSH && (state != IDLE)) begin
                flush_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (iFLUSH) begin
                        valid <= '0;
                    end
                    if (miss_pend) begin
                        miss_pend <= 1'b0;
                        req_cnt   <= '0;
                        req_num   <= '0;
                        rcv_cnt   <= '0;
                        rcv_num   <= '0;
                        state     <= MEMREQ;
                    end
                end
                MEMREQ: begin
                    if (issue) begin
                        req_cnt <= req_cnt + BEAT_ONE;
                        req_num <= req_num + NUM_ONE;
                        if (req_num == NUM_LAST) begin
                            state <= (rcv_num_nxt == NUM_ALL) ? FILL : MEMGET;
                        end
                    end
                end
                MEMGET: begin
                    if (beat_in && (rcv_num == NUM_LAST)) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (fill_go) begin
                        if (flush_pend || iFLUSH) begin
                            valid <= '0;
                        end else begin
                            valid[r_idx] <= 1'b1;
                        end
                        flush_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // line buffer collects returning beats at their wrapped slot; the whole line is committed on FILL exit
    always_ff @(posedge iCLOCK) begin
        if (beat_in) begin
            line_buf[rcv_beat] <= iINST_DATA;
        end
        if (fill_go) begin
            tag_arr[r_idx] <= r_tag;
            for (int b = 0; b < P_LINE_BEATS; b++) begin
                data_arr[r_idx][b] <= line_buf[b];
            end
        end
    end

endmodule

// File: tb/tb_l1_inst_cache_dm_cwf.sv
// Directed bench for l1_inst_cache_dm_cwf with a 2-cycle-latency beat memory.
// Outputs are observed shortly after the falling edge; inputs change on the falling edge.
// Memory returns {A+4, A} for beat address A.
module tb_l1_inst_cache_dm_cwf;

    logic        iCLOCK           = 1'b0;
    logic        iRESET_SYNC      = 1'b1;
    logic        iFLUSH           = 1'b0;
    logic        oINST_REQ;
    logic        iINST_LOCK       = 1'b0;
    logic [31:0] oINST_ADDR;
    logic        iINST_VALID;
    logic [63:0] iINST_DATA;
    logic        iNEXT_FETCH_REQ  = 1'b0;
    logic        oNEXT_FETCH_LOCK;
    logic [31:0] iNEXT_FETCH_ADDR = '0;
    logic        oNEXT_0_INST_VALID;
    logic [31:0] oNEXT_0_INST;
    logic        iNEXT_LOCK       = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 iCLOCK = ~iCLOCK;

    l1_inst_cache_dm_cwf #(
        .P_LINE_BEATS(8),
        .P_ENTRY     (16),
        .P_ADDR_W    (32)
    ) dut (
        .iCLOCK            (iCLOCK),
        .iRESET_SYNC       (iRESET_SYNC),
        .iFLUSH            (iFLUSH),
        .oINST_REQ         (oINST_REQ),
        .iINST_LOCK        (iINST_LOCK),
        .oINST_ADDR        (oINST_ADDR),
        .iINST_VALID       (iINST_VALID),
        .iINST_DATA        (iINST_DATA),
        .iNEXT_FETCH_REQ   (iNEXT_FETCH_REQ),
        .oNEXT_FETCH_LOCK  (oNEXT_FETCH_LOCK),
        .iNEXT_FETCH_ADDR  (iNEXT_FETCH_ADDR),
        .oNEXT_0_INST_VALID(oNEXT_0_INST_VALID),
        .oNEXT_0_INST      (oNEXT_0_INST),
        .iNEXT_LOCK        (iNEXT_LOCK)
    );

    // memory model: accepted request returns its beat two cycles later
    int          cyc   = 0;
    logic        p1_v  = 1'b0;
    logic        p2_v  = 1'b0;
    logic [31:0] p1_a  = '0;
    logic [31:0] p2_a  = '0;
    logic        stray_vld = 1'b0;

    always @(posedge iCLOCK) begin
        cyc  <= cyc + 1;
        p1_v <= oINST_REQ && !iINST_LOCK;
        p1_a <= oINST_ADDR;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end

    assign iINST_VALID = p2_v || stray_vld;
    assign iINST_DATA  = stray_vld ? 64'hBAD0_BAD0_BAD0_BAD0 : {p2_a + 32'd4, p2_a};

    // observation logs, sampled well after the falling edge
    logic [31:0] req_q[$];
    logic [31:0] lock_addr_q[$];
    logic [31:0] out_q[$];
    int          out_cyc_q[$];
    int          beat_cyc_q[$];
    int          req_any = 0;
    int          idle_cyc = 0;

    always @(negedge iCLOCK) begin
        #2;
        if (oINST_REQ) begin
            req_any++;
            if (iINST_LOCK) lock_addr_q.push_back(oINST_ADDR);
            else            req_q.push_back(oINST_ADDR);
        end
        if (iINST_VALID) beat_cyc_q.push_back(cyc);
        if (oNEXT_0_INST_VALID && !iNEXT_LOCK) begin
            out_q.push_back(oNEXT_0_INST);
            out_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int ati(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100;
    endfunction

    task automatic clr();
        req_q.delete();
        lock_addr_q.delete();
        out_q.delete();
        out_cyc_q.delete();
        beat_cyc_q.delete();
        req_any = 0;
    endtask

    // present a fetch until accepted, then withdraw it the following cycle
    task automatic fetch(input logic [31:0] a);
        int n = 0;
        @(negedge iCLOCK);
        iNEXT_FETCH_REQ  = 1'b1;
        iNEXT_FETCH_ADDR = a;
        #1;
        while (oNEXT_FETCH_LOCK && n < 50) begin
            @(negedge iCLOCK);
            #1;
            n++;
        end
        ck("fetch_accept", oNEXT_FETCH_LOCK, 0);
        @(negedge iCLOCK);
        iNEXT_FETCH_REQ = 1'b0;
    endtask

    // wait for the fetch lock to drop, then let the logs catch up one cycle
    task automatic wait_idle();
        int n = 0;
        #1;
        while (oNEXT_FETCH_LOCK && n < 100) begin
            @(negedge iCLOCK);
            #1;
            n++;
        end
        idle_cyc = cyc;
        ck("idle_timeout", oNEXT_FETCH_LOCK, 0);
        @(negedge iCLOCK);
        #3;
    endtask

    task automatic wait_reqs(input int cnt);
        int n = 0;
        while (req_q.size() < cnt && n < 50) begin
            @(negedge iCLOCK);
            #3;
            n++;
        end
        ck("req_wait", (req_q.size() >= cnt), 1);
    endtask

    logic [31:0] s1_exp [8] = '{32'h1010, 32'h1018, 32'h1020, 32'h1028,
                                32'h1030, 32'h1038, 32'h1000, 32'h1008};

    initial begin
        // reset state
        repeat (2) @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        #1;
        ck("rst_req",   oINST_REQ, 0);
        ck("rst_addr",  oINST_ADDR, 0);
        ck("rst_vld",   oNEXT_0_INST_VALID, 0);
        ck("rst_inst",  oNEXT_0_INST, 0);
        ck("rst_lock",  oNEXT_FETCH_LOCK, 0);

        // 1: cold miss, critical-beat-first with wrap and early restart
        clr();
        fetch(32'h0000_1014);
        wait_idle();
        ck("s1_nreq", req_q.size(), 8);
        for (int i = 0; i < 8; i++) ck("s1_req_addr", at(req_q, i), s1_exp[i]);
        ck("s1_nout", out_q.size(), 1);
        ck("s1_inst", at(out_q, 0), 32'h0000_1014);
        ck("s1_early", ati(out_cyc_q, 0), ati(beat_cyc_q, 0) + 1);
        ck("s1_before_last", (ati(out_cyc_q, 0) < ati(beat_cyc_q, 7)), 1);
        ck("s1_lock_until_fill", idle_cyc, ati(beat_cyc_q, 7) + 2);

        // 2: back-to-back hits
        clr();
        @(negedge iCLOCK);
        iNEXT_FETCH_REQ  = 1'b1;
        iNEXT_FETCH_ADDR = 32'h0000_1000;
        #1;
        ck("s2_acc0", oNEXT_FETCH_LOCK, 0);
        @(negedge iCLOCK);
        iNEXT_FETCH_ADDR = 32'h0000_103C;
        #1;
        ck("s2_acc1", oNEXT_FETCH_LOCK, 0);
        ck("s2_vld0", oNEXT_0_INST_VALID, 1);
        @(negedge iCLOCK);
        iNEXT_FETCH_REQ = 1'b0;
        wait_idle();
        ck("s2_nout", out_q.size(), 2);
        ck("s2_inst0", at(out_q, 0), 32'h0000_1000);
        ck("s2_inst1", at(out_q, 1), 32'h0000_103C);
        ck("s2_consec", ati(out_cyc_q, 1), ati(out_cyc_q, 0) + 1);
        ck("s2_no_req", req_any, 0);

        // 4: hit held by iNEXT_LOCK, next fetch waits for it
        clr();
        @(negedge iCLOCK);
        iNEXT_LOCK       = 1'b1;
        iNEXT_FETCH_REQ  = 1'b1;
        iNEXT_FETCH_ADDR = 32'h0000_1018;
        #1;
        ck("s4_acc", oNEXT_FETCH_LOCK, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLOCK);
            iNEXT_FETCH_ADDR = 32'h0000_1000;
            #1;
            ck("s4_hold_vld",  oNEXT_0_INST_VALID, 1);
            ck("s4_hold_inst", oNEXT_0_INST, 32'h0000_1018);
            ck("s4_hold_lock", oNEXT_FETCH_LOCK, 1);
        end
        @(negedge iCLOCK);
        iNEXT_LOCK = 1'b0;
        #1;
        ck("s4_release_lock", oNEXT_FETCH_LOCK, 0);
        @(negedge iCLOCK);
        iNEXT_FETCH_REQ = 1'b0;
        #1;
        ck("s4_next_vld",  oNEXT_0_INST_VALID, 1);
        ck("s4_next_inst", oNEXT_0_INST, 32'h0000_1000);
        wait_idle();
        ck("s4_nout", out_q.size(), 2);
        ck("s4_out0", at(out_q, 0), 32'h0000_1018);
        ck("s4_no_req", req_any, 0);

        // 5: flush during MEMGET still forwards, but leaves nothing valid
        clr();
        fetch(32'h0000_3004);
        wait_reqs(8);
        @(negedge iCLOCK);
        iFLUSH = 1'b1;
        #1;
        ck("s5_flush_lock", oNEXT_FETCH_LOCK, 1);
        @(negedge iCLOCK);
        iFLUSH = 1'b0;
        wait_idle();
        ck("s5_inst", at(out_q, 0), 32'h0000_3004);
        clr();
        fetch(32'h0000_3004);
        wait_idle();
        ck("s5_refetch_miss", req_q.size(), 8);
        ck("s5_refetch_inst", at(out_q, 0), 32'h0000_3004);
        clr();
        fetch(32'h0000_1000);
        wait_idle();
        ck("s5_old_miss", req_q.size(), 8);
        ck("s5_old_inst", at(out_q, 0), 32'h0000_1000);

        // 3: memory lock holds the second request address
        clr();
        fetch(32'h0000_2000);
        wait_reqs(1);
        @(negedge iCLOCK);
        iINST_LOCK = 1'b1;
        repeat (3) @(negedge iCLOCK);
        iINST_LOCK = 1'b0;
        wait_idle();
        ck("s3_nlock", lock_addr_q.size(), 3);
        for (int i = 0; i < 3; i++) ck("s3_hold_addr", at(lock_addr_q, i), 32'h0000_2008);
        ck("s3_nreq", req_q.size(), 8);
        ck("s3_req1", at(req_q, 1), 32'h0000_2008);
        ck("s3_req2", at(req_q, 2), 32'h0000_2010);
        ck("s3_req7", at(req_q, 7), 32'h0000_2038);
        ck("s3_inst", at(out_q, 0), 32'h0000_2000);

        // 6: conflict eviction on index 0
        clr();
        fetch(32'h0000_1014);
        wait_idle();
        ck("s6_a_miss", req_q.size(), 8);
        ck("s6_a_inst", at(out_q, 0), 32'h0000_1014);
        clr();
        fetch(32'h0000_1414);
        wait_idle();
        ck("s6_b_miss", req_q.size(), 8);
        ck("s6_b_inst", at(out_q, 0), 32'h0000_1414);
        clr();
        fetch(32'h0000_1014);
        wait_idle();
        ck("s6_conflict_miss", req_q.size(), 8);
        clr();
        fetch(32'h0000_1014);
        wait_idle();
        ck("s6_rehit", req_any, 0);
        ck("s6_rehit_inst", at(out_q, 0), 32'h0000_1014);

        // 6: reset mid-MEMREQ, stray beats ignored afterwards
        clr();
        fetch(32'h0000_1414);
        wait_reqs(3);
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b1;
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        stray_vld   = 1'b1;
        #1;
        ck("s6r_req",  oINST_REQ, 0);
        ck("s6r_addr", oINST_ADDR, 0);
        ck("s6r_vld",  oNEXT_0_INST_VALID, 0);
        ck("s6r_inst", oNEXT_0_INST, 0);
        ck("s6r_lock", oNEXT_FETCH_LOCK, 0);
        @(negedge iCLOCK);
        stray_vld = 1'b0;
        #1;
        ck("s6r_stray_vld", oNEXT_0_INST_VALID, 0);
        ck("s6r_stray_req", oINST_REQ, 0);
        repeat (4) @(negedge iCLOCK);
        #1;
        ck("s6r_quiet_vld", oNEXT_0_INST_VALID, 0);
        ck("s6r_quiet_inst", oNEXT_0_INST, 0);
        clr();
        fetch(32'h0000_1014);
        wait_idle();
        ck("s6r_post_miss", req_q.size(), 8);
        ck("s6r_post_first", at(req_q, 0), 32'h0000_1010);
        ck("s6r_post_inst", at(out_q, 0), 32'h0000_1014);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
